// File: rtl/fft_pkg.sv
// Shared types, default sizing and the index bit-reversal helper for the FFT reorder buffer.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int LOG2N  = 11;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    // Reverses the low `bits` bits of v; bits above that are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = {r[30:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered output that
// holds its value whenever the read enable is low.
module fft_dpram #(
    parameter int W  = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array and its read register are deliberately left without a reset so
    // they map onto block RAM; control logic alone decides which contents are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer that re-emits each N-sample frame in bit-reversed or natural order.
// Optional macro FFT_REORDER_STATS_EN adds frame_cnt / err_cnt statistics outputs.
module fft_reorder_buf #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int LOG2N  = fft_pkg::LOG2N,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_re,
    input  logic [DATA_W-1:0] din_im,
    input  logic              valid_in,
    input  logic              sop_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] dout_re,
    output logic [DATA_W-1:0] dout_im,
    output logic              valid_out,
    output logic              sop_out,
    output logic              eop_out,
    input  logic              ready_out,
    output logic              frame_err
`ifdef FFT_REORDER_STATS_EN
   ,output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);
    import fft_pkg::*;

    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic             run;
    logic [1:0]       full;
    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             s1_v, s1_sop, s1_eop, s1_bank, out_bank;
    logic             in_xfer, restart, drop, wr_en, wr_last;
    logic             out_adv, s1_ok, rd_issue, freed;
    logic [LOG2N-1:0] wr_addr, rd_addr;
    logic [2*DATA_W-1:0] ram_rdata;

    assign ready_in = run && !full[wr_bank];

    // NOTE: every signal gets a value on every path through always_comb, so no latches.
    always_comb begin
        in_xfer  = valid_in && ready_in;
        restart  = in_xfer && sop_in && (wr_cnt != '0);
        drop     = in_xfer && !sop_in && (wr_cnt == '0);
        wr_en    = in_xfer && !drop;
        wr_last  = wr_en && !sop_in && (wr_cnt == LAST);
        wr_addr  = sop_in ? '0 : wr_cnt;
        out_adv  = !valid_out || ready_out;
        s1_ok    = !s1_v || out_adv;
        rd_issue = full[rd_bank] && s1_ok;
        freed    = valid_out && ready_out && eop_out;
        rd_addr  = (BITREV != 0) ? LOG2N'(bitrev(32'(rd_cnt), LOG2N)) : rd_cnt;
    end

    fft_dpram #(.W(2*DATA_W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_addr}),
        .wdata ({din_re, din_im}),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_rdata)
    );

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            full      <= '0;
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            s1_v      <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_bank   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            run       <= 1'b1;
            frame_err <= restart || drop;
            if (freed)   full[out_bank] <= 1'b0;
            if (wr_last) full[wr_bank]  <= 1'b1;
            if (wr_en) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else if (sop_in) begin
                    wr_cnt  <= LOG2N'(1);
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end
            if (rd_issue) begin
                if (rd_cnt == LAST) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt  <= rd_cnt + 1'b1;
                end
            end
            // Stage 1 is the RAM read register; its data stays put while stage 1 stalls.
            if (s1_ok) begin
                s1_v    <= rd_issue;
                s1_sop  <= rd_cnt == '0;
                s1_eop  <= rd_cnt == LAST;
                s1_bank <= rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
            out_bank  <= 1'b0;
        end else if (out_adv) begin
            valid_out <= s1_v;
            sop_out   <= s1_v && s1_sop;
            eop_out   <= s1_v && s1_eop;
            if (s1_v) begin
                {dout_re, dout_im} <= ram_rdata;
                out_bank           <= s1_bank;
            end
        end
    end

`ifdef FFT_REORDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (freed) frame_cnt <= frame_cnt + 16'd1;
            if ((restart || drop) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench: a bit-reversed and a natural-order instance share one input stream.
module tb_fft_reorder_buf;
    import fft_pkg::*;

    localparam int LG = 3;
    localparam int NN = 1 << LG;

    typedef struct {
        cplx_t d;
        logic  sop;
        logic  eop;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] din_re = '0, din_im = '0;
    logic        valid_in = 1'b0, sop_in = 1'b0, ready_out = 1'b0;

    logic        ready_in_a, valid_a, sop_a, eop_a, ferr_a;
    logic [15:0] dre_a, dim_a;
    logic        ready_in_b, valid_b, sop_b, eop_b, ferr_b;
    logic [15:0] dre_b, dim_b;
`ifdef FFT_REORDER_STATS_EN
    logic [15:0] frame_cnt, err_cnt, frame_cnt_b, err_cnt_b;
`endif

    fft_reorder_buf #(.DATA_W(16), .LOG2N(LG), .BITREV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
        .valid_in(valid_in), .sop_in(sop_in), .ready_in(ready_in_a),
        .dout_re(dre_a), .dout_im(dim_a), .valid_out(valid_a),
        .sop_out(sop_a), .eop_out(eop_a), .ready_out(ready_out), .frame_err(ferr_a)
`ifdef FFT_REORDER_STATS_EN
       ,.frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    fft_reorder_buf #(.DATA_W(16), .LOG2N(LG), .BITREV(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
        .valid_in(valid_in), .sop_in(sop_in), .ready_in(ready_in_b),
        .dout_re(dre_b), .dout_im(dim_b), .valid_out(valid_b),
        .sop_out(sop_b), .eop_out(eop_b), .ready_out(ready_out), .frame_err(ferr_b)
`ifdef FFT_REORDER_STATS_EN
       ,.frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
`endif
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: frames assembled from the framing rules, then emitted in order.
    cplx_t cur[$];
    exp_t  q_a[$], q_b[$];
    int    exp_err = 0, exp_frames = 0, n_acc = 0, last_acc = 0;

    function automatic int rev(input int x);
        int r = 0;
        for (int b = 0; b < LG; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    task automatic model_accept(input cplx_t s, input logic sop);
        if (sop) begin
            if (cur.size() != 0) exp_err++;
            cur.delete();
            cur.push_back(s);
        end else if (cur.size() == 0) begin
            exp_err++;
        end else begin
            cur.push_back(s);
        end
        if (cur.size() == NN) begin
            for (int k = 0; k < NN; k++) begin
                q_a.push_back('{d: cur[rev(k)], sop: (k == 0), eop: (k == NN - 1)});
                q_b.push_back('{d: cur[k],      sop: (k == 0), eop: (k == NN - 1)});
            end
            exp_frames++;
            cur.delete();
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic sop);
        int waited = 0;
        valid_in = 1'b1; din_re = re; din_im = im; sop_in = sop;
        forever begin
            @(negedge clk);
            if (ready_in_a) begin
                @(posedge clk);
                #1;
                model_accept('{re: re, im: im}, sop);
                n_acc++;
                last_acc = cyc;
                break;
            end
            waited++;
            if (waited > 2000) begin
                check("send_timeout_ready_in", ready_in_a, 1);
                break;
            end
        end
        valid_in = 1'b0; sop_in = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 1000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_a_empty", q_a.size(), 0);
        check("drain_b_empty", q_b.size(), 0);
    endtask

    // Monitors: pop and compare whenever an instance transfers a sample.
    int          out_cnt_a = 0, err_seen = 0;
    logic        stall_a = 1'b0;
    logic [33:0] prev_a;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (stall_a) check("a_hold_while_stalled", {dre_a, dim_a, sop_a, eop_a}, prev_a);
            if (ferr_a) err_seen++;
            if (valid_a && ready_out) begin
                check("a_output_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_data", {dre_a, dim_a}, e.d);
                    check("a_sop_eop", {sop_a, eop_a}, {e.sop, e.eop});
                end
                out_cnt_a++;
            end
            stall_a = valid_a && !ready_out;
            prev_a  = {dre_a, dim_a, sop_a, eop_a};
        end else begin
            stall_a = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && valid_b && ready_out) begin
            check("b_output_expected", q_b.size() > 0, 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_data", {dre_b, dim_b}, e.d);
                check("b_sop_eop", {sop_b, eop_b}, {e.sop, e.eop});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, w, vc;
        bit done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_in", ready_in_a, 0);
        check("reset_outputs", {valid_a, sop_a, eop_a, ferr_a, dre_a, dim_a}, 0);
        rst_n = 1'b1;
        #1;
        check("ready_in_before_first_edge", ready_in_a, 0);
        @(posedge clk);
        #1;
        check("ready_in_after_first_edge", ready_in_a, 1);

        // Single frame, latency and ordering (both orders)
        ready_out = 1'b1;
        for (int i = 0; i < NN; i++) send(16'(i), 16'(i + 100), i == 0);
        w = 0;
        while (!valid_a && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("first_output_latency", cyc - last_acc, 2);
        drain();
        check("frame1_output_count", out_cnt_a, NN);

        // Three back-to-back frames against a stalled output
        @(posedge clk); #1;
        ready_out = 1'b0;
        base = n_acc;
        vc = out_cnt_a;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int i = 0; i < NN; i++) send(16'($urandom), 16'($urandom), i == 0);
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                check("bp_accepted_before_stall", n_acc - base, 2 * NN);
                check("bp_ready_in_low", ready_in_a, 0);
                ready_out = 1'b1;
                w = 0;
                repeat (2 * NN) begin
                    @(negedge clk);
                    if (valid_a) w++;
                end
                check("bp_no_gaps_two_frames", w, 2 * NN);
            end
        join
        drain();
        check("bp_output_count", out_cnt_a - vc, 3 * NN);

        // sop_in on the 5th sample restarts the frame
        base = out_cnt_a;
        for (int i = 0; i < 4; i++) send(16'(200 + i), 16'h55, i == 0);
        for (int i = 0; i < NN; i++) send(16'(300 + i), 16'h66, i == 0);
        drain();
        check("restart_frame_err_count", err_seen, exp_err);
        check("restart_only_new_frame", out_cnt_a - base, NN);
`ifdef FFT_REORDER_STATS_EN
        check("restart_err_cnt", err_cnt, 1);
`endif

        // Sample without sop at count 0 is dropped
        base = out_cnt_a;
        send(16'hBEEF, 16'h1234, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("stray_frame_err_count", err_seen, exp_err);
        check("stray_no_output", out_cnt_a - base, 0);
        check("stray_valid_out_low", valid_a, 0);

        // Randomized traffic with gaps, truncated frames and random back-pressure
        done = 0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int len = $urandom_range(1, NN - 2);
                        for (int j = 0; j < len; j++) send(16'($urandom), 16'($urandom), j == 0);
                    end
                    for (int i = 0; i < NN; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                        send(16'($urandom), 16'($urandom), i == 0);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ready_out = ($urandom_range(0, 3) != 0);
                end
                ready_out = 1'b1;
            end
        join
        drain();
        check("random_frame_err_count", err_seen, exp_err);
        check("random_total_outputs", out_cnt_a, exp_frames * NN);
`ifdef FFT_REORDER_STATS_EN
        check("stats_err_cnt", err_cnt, exp_err);
        check("stats_frame_cnt", frame_cnt, exp_frames);
`endif

        // Reset while the 4th output sample is presented
        base = out_cnt_a;
        for (int i = 0; i < NN; i++) send(16'(500 + i), 16'(600 + i), i == 0);
        w = 0;
        while (out_cnt_a < base + 3 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("reset_mid_frame_valid_before", valid_a, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs_a", {valid_a, sop_a, eop_a, ferr_a, dre_a, dim_a, ready_in_a}, 0);
        check("reset_mid_outputs_b", {valid_b, sop_b, eop_b, ferr_b, dre_b, dim_b, ready_in_b}, 0);
`ifdef FFT_REORDER_STATS_EN
        check("reset_stats", {frame_cnt, err_cnt}, 0);
`endif
        q_a.delete();
        q_b.delete();
        cur.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_release_ready_in_low", ready_in_a, 0);
        @(posedge clk);
        #1;
        check("reset_release_ready_in_high", ready_in_a, 1);
        base = out_cnt_a;
        for (int i = 0; i < NN; i++) send(16'(700 + i), 16'(800 + i), i == 0);
        drain();
        check("post_reset_output_count", out_cnt_a - base, NN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
